// File: rtl/overture_pc_sequencer.sv
// PC/fetch/issue sequencer: accept an instruction, issue it for one cycle, then branch to reg0 or step pc.
// Latency: 2 cycles per instruction at best; backpressure via instr_valid/instr_ready, en=0 freezes everything.
module overture_pc_sequencer #(
  parameter int PC_WIDTH       = 8,
  parameter int CNT_WIDTH      = 16,
  parameter bit SELF_LOOP_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 instr_valid,
  input  logic [7:0]           instr,
  output logic                 instr_ready,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [7:0]           ir,
  output logic                 issue,
  input  logic                 cond_true,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [CNT_WIDTH-1:0] taken
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_d;
  logic [7:0]           ir_d;
  logic [CNT_WIDTH-1:0] retired_d, taken_d;
  logic                 br_take;
  logic                 self_loop;

  assign br_take   = (ir[7:6] == 2'b11) && cond_true;
  assign self_loop = SELF_LOOP_HALT && br_take && (branch_target == pc);
  assign halted    = (state_q == HALT);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc;
    ir_d        = ir;
    retired_d   = retired;
    taken_d     = taken;
    instr_ready = 1'b0;
    issue       = 1'b0;
    // Nothing moves while in reset or while the core is disabled.
    if (rst && en) begin
      case (state_q)
        FETCH: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            ir_d    = instr;
            state_d = EXEC;
          end else if (halt_req) begin
            state_d = HALT;
          end
        end
        EXEC: begin
          issue     = 1'b1;
          pc_d      = br_take ? branch_target : pc + PC_WIDTH'(1);
          retired_d = (retired == '1) ? retired : retired + CNT_WIDTH'(1);
          if (br_take && (taken != '1)) begin
            taken_d = taken + CNT_WIDTH'(1);
          end
          state_d   = (halt_req || self_loop) ? HALT : FETCH;
        end
        HALT: begin
          if (resume) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
      taken   <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      ir      <= ir_d;
      retired <= retired_d;
      taken   <= taken_d;
    end
  end

endmodule
